// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: word fetch engine feeding the realign buffer.
// Credit-limited requests, response FIFO, redirect with in-flight discard.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   fetch_en_i           allow new memory requests
//   branch_i             one-cycle redirect strobe
//   branch_addr_i        redirect target (halfword aligned)
//   imem_req_o           registered memory request
//   imem_addr_o          registered word-aligned request address
//   imem_gnt_i           request accepted this cycle
//   imem_rvalid_i        in-order response valid
//   imem_rdata_i         response data
//   rb_write_en_o        write strobe to realign buffer
//   rb_instr_o           FIFO head word
//   rb_addr_o            FIFO head word address
//   rb_full_i            realign buffer full
//   rb_clear_o           realign buffer clear (branch cycle)
//   rb_read_offset_o     halfword offset applied with clear
//   busy_o               request, response or FIFO data pending
//
// Optional feature macro IFETCH_STATS_EN adds saturating counters
//   stat_stall_cnt_o     cycles with FIFO data blocked by rb_full_i
//   stat_discard_cnt_o   responses dropped after a redirect
module instr_fetch_ctrl #(
    parameter int RISCV_ADDR_WIDTH = 32,
    parameter int RISCV_WORD_WIDTH = 32,
    parameter int FIFO_DEPTH       = 2,
    parameter int MAX_OUTSTANDING  = 2,
    parameter logic [RISCV_ADDR_WIDTH-1:0] BOOT_ADDR = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_en_i,
    input  logic                        branch_i,
    input  logic [RISCV_ADDR_WIDTH-1:0] branch_addr_i,
    output logic                        imem_req_o,
    output logic [RISCV_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                        imem_gnt_i,
    input  logic                        imem_rvalid_i,
    input  logic [RISCV_WORD_WIDTH-1:0] imem_rdata_i,
    output logic                        rb_write_en_o,
    output logic [RISCV_WORD_WIDTH-1:0] rb_instr_o,
    output logic [RISCV_ADDR_WIDTH-1:0] rb_addr_o,
    input  logic                        rb_full_i,
    output logic                        rb_clear_o,
    output logic                        rb_read_offset_o,
    output logic                        busy_o
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0]                 stat_stall_cnt_o,
    output logic [31:0]                 stat_discard_cnt_o
`endif
);

    localparam int AW = RISCV_ADDR_WIDTH;
    localparam int WW = RISCV_WORD_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 3;
    localparam logic [AW-1:0] BOOT_ALIGNED = {BOOT_ADDR[AW-1:2], 2'b00};

    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [AW-1:0] fetch_addr;
    logic [AW-1:0] resp_addr;
    // pending request was issued before the last redirect
    logic          stale;

    logic [WW-1:0] fifo_data [FIFO_DEPTH];
    logic [AW-1:0] fifo_addr [FIFO_DEPTH];

    logic          gnt;
    logic          push;
    logic          pop;
    logic          drop_q;
    logic          launch;
    logic [CW-1:0] out_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [AW-1:0] fetch_inc;
    logic [AW-1:0] next_req_addr;
    logic [AW-1:0] br_target;
    logic          unused_addr0;

    assign unused_addr0 = branch_addr_i[0];

    assign gnt       = imem_req_o & imem_gnt_i;
    assign drop_q    = imem_rvalid_i & (discard != '0);
    assign push      = imem_rvalid_i & ~branch_i & (discard == '0);
    assign pop       = rb_write_en_o;
    assign br_target = {branch_addr_i[AW-1:2], 2'b00};
    assign fetch_inc = fetch_addr + AW'(4);

    // every rvalid retires an outstanding slot, dropped or not
    assign out_nxt = outstanding + CW'(gnt) - CW'(imem_rvalid_i);
    assign cnt_nxt = branch_i ? '0
                   : fifo_cnt + CW'(push) - CW'(pop);

    // credits are judged on next-state counts so a request can be
    // issued in the grant cycle of the previous one
    assign launch = fetch_en_i & ~branch_i
                  & ~(imem_req_o & ~gnt)
                  & (out_nxt < CW'(MAX_OUTSTANDING))
                  & ((out_nxt + cnt_nxt) < CW'(FIFO_DEPTH));

    // a stale grant must not advance the post-redirect address
    assign next_req_addr = (gnt & ~stale) ? fetch_inc : fetch_addr;

    assign rb_write_en_o    = (fifo_cnt != '0) & ~rb_full_i
                            & ~branch_i & ~rst;
    assign rb_instr_o       = fifo_data[rptr];
    assign rb_addr_o        = fifo_addr[rptr];
    assign rb_clear_o       = branch_i & ~rst;
    assign rb_read_offset_o = branch_addr_i[1] & branch_i & ~rst;

    assign busy_o = imem_req_o | (outstanding != '0)
                  | (fifo_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_req_o  <= 1'b0;
            imem_addr_o <= BOOT_ALIGNED;
            fetch_addr  <= BOOT_ALIGNED;
            resp_addr   <= BOOT_ALIGNED;
            outstanding <= '0;
            discard     <= '0;
            stale       <= 1'b0;
            fifo_cnt    <= '0;
            wptr        <= '0;
            rptr        <= '0;
        end else begin
            outstanding <= out_nxt;
            fifo_cnt    <= cnt_nxt;

            if (launch) begin
                imem_req_o  <= 1'b1;
                imem_addr_o <= next_req_addr;
            end else if (gnt) begin
                imem_req_o  <= 1'b0;
            end

            if (branch_i) begin
                fetch_addr <= br_target;
                resp_addr  <= br_target;
                // recomputed, not accumulated: everything in flight
                discard    <= out_nxt + CW'(imem_req_o & ~gnt);
                stale      <= imem_req_o & ~gnt;
                wptr       <= '0;
                rptr       <= '0;
            end else begin
                if (gnt & ~stale) begin
                    fetch_addr <= fetch_inc;
                end
                if (gnt) begin
                    stale <= 1'b0;
                end
                if (drop_q) begin
                    discard <= discard - CW'(1);
                end
                if (push) begin
                    wptr      <= wptr + PW'(1);
                    resp_addr <= resp_addr + AW'(4);
                end
                if (pop) begin
                    rptr <= rptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wptr] <= imem_rdata_i;
            fifo_addr[wptr] <= resp_addr;
        end
    end

    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst)
        !(push && !pop && fifo_cnt == CW'(FIFO_DEPTH))
    );

`ifdef IFETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cnt_o   <= '0;
            stat_discard_cnt_o <= '0;
        end else begin
            if ((fifo_cnt != '0) && rb_full_i
                && (stat_stall_cnt_o != '1)) begin
                stat_stall_cnt_o <= stat_stall_cnt_o + 32'd1;
            end
            if (imem_rvalid_i && (branch_i || discard != '0)
                && (stat_discard_cnt_o != '1)) begin
                stat_discard_cnt_o <= stat_discard_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
